spi_frame_tx: RTL
=================

Name: spi_frame_tx

Overview:
FPGA-side SPI peripheral transmitter: the return path to the MCU, complementing the existing 128-bit frame receiver. Accepts a 128-bit status frame from fabric logic via valid/ready and shifts it out on sdo when the MCU asserts load and clocks sck. Default frame packing is {x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4, r, g, b}, MSB first. Single clock domain: sck and load are oversampled by clk.

Parameters:
FRAME_W, 128, frame length in bits.
SYNC_STAGES, 2, synchronizer depth for sck and load (legal range 2..3).

Ports:
clk  input  1  system clock; all state is on posedge clk.
reset_n  input  1  asynchronous active-low reset.
frame_data  input  FRAME_W  frame to send; bit FRAME_W-1 goes out first.
frame_valid  input  1  frame_data valid.
frame_ready  output  1  block can accept a frame; a transfer occurs when frame_valid & frame_ready.
sck  input  1  SPI clock from MCU; mode 0 (CPOL=0, CPHA=0).
load  input  1  frame enable from MCU, active high.
sdo  output  1  serial data to MCU, registered.
busy  output  1  high in ARMED and SHIFT.
done  output  1  one-clk pulse after the last bit has been sampled.
underrun  output  1  one-clk pulse when load rises with no frame latched.
aborted  output  1  one-clk pulse when load falls before FRAME_W bits are sent.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; shreg=0; bit_cnt=0; all sync flops=0.
  - sdo=0; frame_ready=0 while reset_n is low, 1 on the first clk after release.
  - busy, done, underrun, aborted all 0.
- Synchronizers: sck and load each pass through SYNC_STAGES flops.
  - Edges are detected from the last stage against a one-flop history.
  - sck high and low times must each be at least SYNC_STAGES+2 clk periods. Bench uses sck = clk/8.
- bit_cnt: clog2(FRAME_W)+1 bits wide; never wraps.
- IDLE:
  - frame_ready=1, sdo=0.
  - On handshake: shreg<=frame_data, go ARMED.
  - On load rise without a handshake: shreg<=0, underrun pulse, go SHIFT (all zeros are transmitted).
  - Handshake and load rise in the same clk: the frame is latched, go SHIFT directly, no underrun.
- ARMED:
  - frame_ready=0; frame_valid is ignored.
  - sdo=shreg[FRAME_W-1], so the first bit is valid before the first sck rise.
  - On load rise: bit_cnt<=0, go SHIFT.
- SHIFT:
  - Each synced sck rise: bit_cnt<=bit_cnt+1. The MCU samples on this edge.
  - Each synced sck fall with bit_cnt<FRAME_W: shreg<=shreg<<1, zero fill; sdo follows the new shreg[FRAME_W-1] on the next clk.
  - When bit_cnt reaches FRAME_W: done pulse, go DONE.
  - Latency from synced sck fall to sdo change is 1 clk. From the raw pin it is at most SYNC_STAGES+2 clk.
- DONE:
  - sdo=0; further sck edges are ignored.
  - On load fall: go IDLE.
- Abort: load fall in SHIFT with bit_cnt<FRAME_W gives an aborted pulse, shreg<=0, sdo=0, go IDLE. The frame is discarded, not resent.
- Load fall in ARMED: stay ARMED, keep the frame (covers MCU glitches before a transfer starts).
- sck edges while load is low: ignored in every state.
- Simultaneous synced sck and load edges in the same clk: the load edge has priority.
- The done, underrun and aborted pulses are mutually exclusive and last exactly 1 clk.

Test Plan:
- Reset check: assert reset_n=0 mid-SHIFT after 40 bits → sdo=0, busy=0 immediately; frame_ready=1 one clk after release; next load rise with no frame gives an underrun pulse.
- Nominal frame: frame_data=128'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_7654, frame_valid for 1 clk → frame_ready drops, busy=1. Then load=1 and 128 sck cycles at clk/8 → MCU-side samples on sck rise equal the frame MSB first. After the 128th rise, done pulses once; sdo=0 after that.
- Back-to-back frames: send 128'h1, drop load, then send 128'h8000…0 → second capture is correct; frame_ready returns to 1 only after load falls.
- Underrun: load rises with no frame → 1-clk underrun pulse; 128 zeros shifted; done still pulses.
- Abort: load falls after 57 sck cycles → aborted pulse, state IDLE. The next frame 128'hFFFF…F transmits fully with no stale bits.
- Handshake and load rise in the same clk with frame 128'hDEAD_BEEF… → no underrun; first sampled bit = 1.

Source files
------------

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter: latches a FRAME_W-bit frame over valid/ready and
// shifts it out MSB first on sdo while the MCU holds load high and clocks sck.
module spi_frame_tx #(
   parameter int FRAME_W     = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [FRAME_W-1:0] frame_data,
   input  logic               frame_valid,
   output logic               frame_ready,
   input  logic               sck,
   input  logic               load,
   output logic               sdo,
   output logic               busy,
   output logic               done,
   output logic               underrun,
   output logic               aborted
);

   localparam int               CNT_W    = $clog2(FRAME_W) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [FRAME_W-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, load_sync_q;
   logic                   sck_hist_q, load_hist_q;
   logic                   sdo_q, sdo_d;
   logic                   ready_q, ready_d;
   logic                   done_q, done_d;
   logic                   underrun_q, underrun_d;
   logic                   aborted_q, aborted_d;

   logic sck_s, load_s;
   logic sck_rise, sck_fall, load_rise, load_fall, handshake;

   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign load_s    = load_sync_q[SYNC_STAGES-1];
   // sck edges only count while the MCU holds load high.
   assign sck_rise  =  sck_s & ~sck_hist_q & load_s;
   assign sck_fall  = ~sck_s &  sck_hist_q & load_s;
   assign load_rise =  load_s & ~load_hist_q;
   assign load_fall = ~load_s &  load_hist_q;
   assign handshake = frame_valid & ready_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q  <= '0;
         load_sync_q <= '0;
         sck_hist_q  <= 1'b0;
         load_hist_q <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
         sck_hist_q  <= sck_s;
         load_hist_q <= load_s;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      aborted_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_rise) begin
               shreg_d    = handshake ? frame_data : '0;
               underrun_d = ~handshake;
               bit_cnt_d  = '0;
               state_d    = S_SHIFT;
            end else if (handshake) begin
               shreg_d = frame_data;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (load_rise) begin
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (load_fall && (bit_cnt_q < CNT_FULL)) begin
               aborted_d = 1'b1;
               shreg_d   = '0;
               state_d   = S_IDLE;
            end else if (bit_cnt_q == CNT_FULL) begin
               done_d  = 1'b1;
               state_d = load_fall ? S_IDLE : S_DONE;
            end else if (sck_rise) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (sck_fall) begin
               shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            end
         end
         S_DONE: begin
            if (load_fall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      sdo_d   = ((state_d == S_ARMED) || (state_d == S_SHIFT)) ? shreg_d[FRAME_W-1] : 1'b0;
      ready_d = (state_d == S_IDLE);
   end

   // frame_ready is a flop so it reads 0 throughout reset and rises on the first clk after.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         sdo_q      <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         sdo_q      <= sdo_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         aborted_q  <= aborted_d;
      end
   end

   assign frame_ready = ready_q;
   assign sdo         = sdo_q;
   assign busy        = (state_q == S_ARMED) || (state_q == S_SHIFT);
   assign done        = done_q;
   assign underrun    = underrun_q;
   assign aborted     = aborted_q;

endmodule
